// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg: shared definitions for the temperature fan controller.
//   level_e   - 2-bit fan level encoding (LOW/MED/HIGH/CRIT)
//   level_of  - highest level whose threshold the temperature meets
//   duty_of   - PWM duty for a level (CRIT uses the caller's all-ones value)
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        LVL_LOW  = 2'd0,
        LVL_MED  = 2'd1,
        LVL_HIGH = 2'd2,
        LVL_CRIT = 2'd3
    } level_e;

    function automatic level_e level_of(input int unsigned temp,
                                        input int unsigned t_med,
                                        input int unsigned t_high,
                                        input int unsigned t_crit);
        level_e lvl;
        lvl = LVL_LOW;
        if (temp >= t_crit) begin
            lvl = LVL_CRIT;
        end else if (temp >= t_high) begin
            lvl = LVL_HIGH;
        end else if (temp >= t_med) begin
            lvl = LVL_MED;
        end
        return lvl;
    endfunction

    function automatic logic [31:0] duty_of(input level_e      level,
                                            input logic [31:0] d_low,
                                            input logic [31:0] d_med,
                                            input logic [31:0] d_high,
                                            input logic [31:0] d_max);
        logic [31:0] duty;
        duty = d_low;
        unique case (level)
            LVL_LOW:  duty = d_low;
            LVL_MED:  duty = d_med;
            LVL_HIGH: duty = d_high;
            LVL_CRIT: duty = d_max;
            default:  duty = d_low;
        endcase
        return duty;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM with duty latched at counter wrap and registered output.
// Ports:
//   clk     - clock
//   rst_n   - synchronous active-low reset
//   duty    - requested duty; sampled only when the counter is 0
//   pwm_out - registered PWM drive; all-ones duty gives constant 1, 0 gives constant 0
module pwm_gen #(
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_out
);

    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_duty;
    logic             r_pwm;
    logic [PWM_W-1:0] w_duty_eff;
    logic             w_pwm_d;

    // At counter 0 the new duty already governs this slot, so the whole
    // period starting at 0 runs at the new duty.
    always_comb begin
        w_duty_eff = r_duty;
        if (r_cnt == '0) begin
            w_duty_eff = duty;
        end
        w_pwm_d = (r_cnt < w_duty_eff) || (&w_duty_eff);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_duty <= w_duty_eff;
            r_pwm  <= w_pwm_d;
        end
    end

    assign pwm_out = r_pwm;

endmodule

// File: rtl/temp_fan_pwm_ctrl.sv
// temp_fan_pwm_ctrl: temperature-to-fan-level controller with hysteresis,
// dwell filtering, immediate CRIT escalation and PWM fan drive.
// Ports:
//   clk          - clock
//   rst_n        - synchronous active-low reset
//   temp_valid   - qualifies temp_in
//   temp_in      - sensor temperature (unsigned)
//   fan_speed    - committed level: 00 LOW, 01 MED, 10 HIGH, 11 CRIT
//   pwm_out      - fan PWM drive (registered)
//   overtemp     - high while the committed level is CRIT
//   level_change - one-cycle pulse after each commit
module temp_fan_pwm_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned TEMP_W    = 8,
    parameter int unsigned T_MED     = 20,
    parameter int unsigned T_HIGH    = 41,
    parameter int unsigned T_CRIT    = 100,
    parameter int unsigned HYST      = 2,
    parameter int unsigned DWELL     = 16,
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned DUTY_LOW  = 64,
    parameter int unsigned DUTY_MED  = 160,
    parameter int unsigned DUTY_HIGH = 224
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp_in,
    output logic [1:0]        fan_speed,
    output logic              pwm_out,
    output logic              overtemp,
    output logic              level_change
);

    localparam int unsigned       CNT_W    = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);

    logic [TEMP_W-1:0] r_temp_q;
    level_e            r_cur;
    level_e            r_pend;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_level_change;

    logic [31:0]       w_temp;
    level_e            w_r_up;
    level_e            w_r_dn;
    level_e            w_target;
    level_e            w_cur_d;
    level_e            w_pend_d;
    logic [CNT_W-1:0]  w_cnt_d;
    logic              w_commit;
    logic [31:0]       w_duty32;
    logic [PWM_W-1:0]  w_duty;

    assign w_temp = 32'(r_temp_q);
    assign w_r_up = level_of(w_temp, T_MED, T_HIGH, T_CRIT);
    assign w_r_dn = level_of(w_temp, T_MED - HYST, T_HIGH - HYST, T_CRIT - HYST);

    // Rising uses the plain thresholds, falling the hysteresis-lowered ones;
    // between the two the current level holds.
    always_comb begin
        w_target = r_cur;
        if (w_r_up > r_cur) begin
            w_target = w_r_up;
        end else if (w_r_dn < r_cur) begin
            w_target = w_r_dn;
        end
    end

    // Dwell filter: a non-CRIT target must stay unchanged for DWELL cycles
    // after being captured in r_pend before it is committed. CRIT bypasses it.
    always_comb begin
        w_cur_d  = r_cur;
        w_pend_d = r_pend;
        w_cnt_d  = r_cnt;
        w_commit = 1'b0;
        if (w_target == LVL_CRIT) begin
            w_cur_d  = LVL_CRIT;
            w_pend_d = LVL_CRIT;
            w_cnt_d  = '0;
            w_commit = (r_cur != LVL_CRIT);
        end else if (w_target != r_pend) begin
            w_pend_d = w_target;
            w_cnt_d  = '0;
        end else if (r_pend != r_cur) begin
            if (r_cnt == CNT_LAST) begin
                w_cur_d  = r_pend;
                w_cnt_d  = '0;
                w_commit = 1'b1;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end else begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_temp_q       <= '0;
            r_cur          <= LVL_LOW;
            r_pend         <= LVL_LOW;
            r_cnt          <= '0;
            r_level_change <= 1'b0;
        end else begin
            if (temp_valid) begin
                r_temp_q <= temp_in;
            end
            r_cur          <= w_cur_d;
            r_pend         <= w_pend_d;
            r_cnt          <= w_cnt_d;
            r_level_change <= w_commit;
        end
    end

    assign w_duty32 = duty_of(r_cur, 32'(DUTY_LOW), 32'(DUTY_MED), 32'(DUTY_HIGH),
                              32'({PWM_W{1'b1}}));
    assign w_duty   = w_duty32[PWM_W-1:0];

    pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (w_duty),
        .pwm_out (pwm_out)
    );

    assign fan_speed    = r_cur;
    assign overtemp     = (r_cur == LVL_CRIT);
    assign level_change = r_level_change;

endmodule

// File: tb/tb_temp_fan_pwm_ctrl.sv
// tb_temp_fan_pwm_ctrl: directed and randomized bench for temp_fan_pwm_ctrl
// (DWELL=4, PWM_W=4, duties 4/10/14) against a behavioural reference model.
module tb_temp_fan_pwm_ctrl;

    localparam int DWELL = 4;
    localparam int NPER  = 16;

    logic       clk;
    logic       rst_n;
    logic       temp_valid;
    logic [7:0] temp_in;
    logic [1:0] fan_speed;
    logic       pwm_out;
    logic       overtemp;
    logic       level_change;

    temp_fan_pwm_ctrl #(
        .DWELL     (4),
        .PWM_W     (4),
        .DUTY_LOW  (4),
        .DUTY_MED  (10),
        .DUTY_HIGH (14)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .temp_valid   (temp_valid),
        .temp_in      (temp_in),
        .fan_speed    (fan_speed),
        .pwm_out      (pwm_out),
        .overtemp     (overtemp),
        .level_change (level_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_lc     = 0;
    int n_hi     = 0;

    // Reference model state. Commit rule: a non-CRIT target different from the
    // current level commits once the same target has been seen on DWELL+1
    // consecutive edges (reset counts as having seen LOW).
    int m_tq, m_cur, m_prev_tgt, m_run, m_lc, m_pcnt, m_dact, m_pwm;
    int duty_tab [4] = '{4, 10, 14, 15};
    int thr      [3] = '{20, 41, 100};

    function automatic int lvl(input int t, input int off);
        int l = 0;
        for (int i = 0; i < 3; i++) begin
            if (t >= thr[i] - off) l = i + 1;
        end
        return l;
    endfunction

    task automatic model_step();
        int up, dn, tgt, eff;
        if (!rst_n) begin
            m_tq = 0; m_cur = 0; m_prev_tgt = 0; m_run = 0; m_lc = 0;
            m_pcnt = 0; m_dact = 0; m_pwm = 0;
        end else begin
            up  = lvl(m_tq, 0);
            dn  = lvl(m_tq, 2);
            tgt = (up > m_cur) ? up : ((dn < m_cur) ? dn : m_cur);
            m_run      = (tgt == m_prev_tgt) ? m_run + 1 : 1;
            m_prev_tgt = tgt;
            eff   = (m_pcnt == 0) ? duty_tab[m_cur] : m_dact;
            m_pwm = ((m_pcnt < eff) || (eff == 15)) ? 1 : 0;
            m_dact = eff;
            m_pcnt = (m_pcnt + 1) % NPER;
            m_lc = 0;
            if (tgt == 3) begin
                m_lc  = (m_cur != 3) ? 1 : 0;
                m_cur = 3;
            end else if (tgt != m_cur && m_run >= DWELL + 1) begin
                m_lc  = 1;
                m_cur = tgt;
            end
            if (temp_valid) m_tq = int'(temp_in);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("fan_speed", 32'(fan_speed), 32'(m_cur));
        check("overtemp", 32'(overtemp), 32'(m_cur == 3));
        check("level_change", 32'(level_change), 32'(m_lc));
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        n_lc += int'(level_change);
        n_hi += int'(pwm_out);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sample(input int t);
        temp_in    = 8'(t);
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
    endtask

    int lc0;

    initial begin
        rst_n      = 1'b0;
        temp_valid = 1'b1;
        temp_in    = 8'd90;

        // Reset holds everything at zero even with a valid temperature present.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_temp_q", 32'(dut.r_temp_q), 32'd0);
            check("reset_fan", 32'(fan_speed), 32'd0);
        end
        rst_n      = 1'b1;
        temp_valid = 1'b0;

        // LOW -> MED takes exactly DWELL+1 edges after the sample edge.
        sample(10);
        ticks(3);
        lc0 = n_lc;
        sample(25);
        ticks(4);
        check("med_not_yet", 32'(fan_speed), 32'd0);
        tick();
        check("med_commit", 32'(fan_speed), 32'd1);
        ticks(20);
        check("med_pulses", 32'(n_lc - lc0), 32'd1);
        n_hi = 0;
        ticks(16);
        check("med_duty", 32'(n_hi), 32'd10);

        // Hysteresis band holds MED; below it drops to LOW.
        sample(19);
        ticks(20);
        check("hyst_hold", 32'(fan_speed), 32'd1);
        sample(17);
        ticks(10);
        check("hyst_drop", 32'(fan_speed), 32'd0);

        // Chatter never survives the dwell filter.
        lc0 = n_lc;
        temp_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            temp_in = 8'd20;
            ticks(2);
            temp_in = 8'd10;
            ticks(2);
        end
        temp_valid = 1'b0;
        check("chatter_fan", 32'(fan_speed), 32'd0);
        check("chatter_pulses", 32'(n_lc - lc0), 32'd0);

        // CRIT escalates on the next edge and drives full duty.
        sample(10);
        ticks(2);
        sample(120);
        tick();
        check("crit_fan", 32'(fan_speed), 32'd3);
        check("crit_overtemp", 32'(overtemp), 32'd1);
        ticks(20);
        n_hi = 0;
        ticks(16);
        check("crit_duty", 32'(n_hi), 32'd16);
        sample(98);
        ticks(20);
        check("crit_hold_98", 32'(fan_speed), 32'd3);
        sample(97);
        ticks(10);
        check("crit_leave_97", 32'(fan_speed), 32'd2);

        // Multi-level jump with one pulse, then reset abandons a dwell.
        sample(10);
        ticks(10);
        check("back_low", 32'(fan_speed), 32'd0);
        lc0 = n_lc;
        sample(50);
        ticks(10);
        check("jump_high", 32'(fan_speed), 32'd2);
        check("jump_pulses", 32'(n_lc - lc0), 32'd1);
        sample(10);
        ticks(10);
        lc0 = n_lc;
        sample(50);
        ticks(2);
        rst_n = 1'b0;
        tick();
        check("rst_mid_fan", 32'(fan_speed), 32'd0);
        check("rst_mid_cnt", 32'(dut.r_cnt), 32'd0);
        rst_n = 1'b1;
        ticks(10);
        check("rst_mid_stay", 32'(fan_speed), 32'd0);
        check("rst_mid_pulses", 32'(n_lc - lc0), 32'd0);

        // Randomized segments around the thresholds, with occasional resets.
        for (int s = 0; s < 120; s++) begin
            int t;
            case ($urandom_range(0, 3))
                0:       t = 20 + $urandom_range(0, 4) - 3;
                1:       t = 41 + $urandom_range(0, 4) - 3;
                2:       t = 100 + $urandom_range(0, 4) - 3;
                default: t = $urandom_range(0, 255);
            endcase
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            sample(t);
            ticks($urandom_range(0, 9));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
